// File: rtl/program_loader.sv
// program_loader: boot-time image loader for the stack processor.
// Accepts a length-framed byte stream, writes the payload into the unified
// memory, zero-fills the remaining words and releases the processor reset
// only after a complete, well-formed image.
// Optional feature macro: LOADER_CSUM_EN adds a trailing checksum byte that
// must match the modulo-2**DATA_W sum of the payload.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);
    // One extra bit so the counter can hold DEPTH itself (N==DEPTH, end of fill).
    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        LOAD  = 3'd2,
`ifdef LOADER_CSUM_EN
        CSUM  = 3'd3,
`endif
        FILL  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic             xfer;
    logic             ready_next;
    logic             hold_done;
    logic             last_byte;
    state_t           after_payload;
`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign xfer      = in_valid && in_ready;
    assign last_byte = (cnt + CNT_ONE) == len;
    // A full-depth image has nothing to fill, so skip straight to DONE.
    assign after_payload = (len == CNT_DEPTH) ? DONE : FILL;
    // done/cpu_rst change one cycle after reaching DONE, so the release is
    // seen only after the last write cycle has been presented.
    assign hold_done = (state == DONE) && (next_state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = LEN;
            LEN: if (xfer) begin
                if (in_data == '0 || 32'(in_data) > 32'(DEPTH)) next_state = ERROR;
                else                                            next_state = LOAD;
            end
            LOAD: if (xfer && last_byte) begin
`ifdef LOADER_CSUM_EN
                next_state = CSUM;
`else
                next_state = after_payload;
`endif
            end
`ifdef LOADER_CSUM_EN
            CSUM: if (xfer) next_state = (in_data == acc) ? after_payload : ERROR;
`endif
            FILL: if (cnt == CNT_LAST) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready is registered, so derive it from where the FSM is heading.
    always_comb begin
        ready_next = (next_state == LEN) || (next_state == LOAD);
`ifdef LOADER_CSUM_EN
        ready_next = ready_next || (next_state == CSUM);
`endif
    end

    // Datapath: counters, memory write port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            len       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CSUM_EN
            acc       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    cnt <= '0;
`ifdef LOADER_CSUM_EN
                    acc <= '0;
`endif
                end
                LEN: if (xfer) len <= in_data[CNT_W-1:0];
                LOAD: if (xfer) begin
                    mem_we    <= 1'b1;
                    mem_adr   <= cnt[ADDR_W-1:0];
                    mem_wdata <= in_data;
                    cnt       <= cnt + CNT_ONE;
`ifdef LOADER_CSUM_EN
                    acc       <= acc + in_data;
`endif
                end
                FILL: begin
                    mem_we    <= 1'b1;
                    mem_adr   <= cnt[ADDR_W-1:0];
                    mem_wdata <= '0;
                    cnt       <= cnt + CNT_ONE;
                end
                default: ;
            endcase
            in_ready <= ready_next;
            done     <= hold_done;
            cpu_rst  <= !hold_done;
            error    <= (next_state == ERROR);
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Expected memory
// writes are queued as bytes are driven and popped by a write monitor.
// Build with +define+LOADER_CSUM_EN to exercise the checksum variant.
module tb_program_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] sb[$];
    logic [7:0]  pay[DEPTH];

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every DUT write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (sb.size() == 0) begin
                check("spurious_we", 32'(mem_we), 32'd0);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                check("wr_adr", 32'(mem_adr), 32'(e[12:8]));
                check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drive one byte and hold it until the edge where it is accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_flag(input bit want_done, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(want_done ? done : error) && cyc < 200);
    endtask

    task automatic push_fill(input int n);
        for (int a = n; a < DEPTH; a++) sb.push_back({5'(a), 8'h00});
    endtask

    task automatic begin_frame();
        do_start();
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(error), 32'd0);
        check("start_cpu_rst", 32'(cpu_rst), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
    endtask

    // Complete good frame from pay[0..n-1]; optional random valid gaps and a
    // stray start pulse in the middle of the payload.
    task automatic run_good(input int n, input bit gaps, input bit poke);
        logic [7:0] sum;
        int cyc;
        sum = 8'h00;
        begin_frame();
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            if (poke && i == n / 2) begin
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            sum = sum + pay[i];
            sb.push_back({5'(i), pay[i]});
`ifndef LOADER_CSUM_EN
            if (i == n - 1) push_fill(n);
`endif
            send(pay[i]);
            check("load_cpu_rst", 32'(cpu_rst), 32'd1);
        end
`ifdef LOADER_CSUM_EN
        push_fill(n);
        send(sum);
`endif
        wait_flag(1'b1, cyc);
        check("done_latency", 32'(cyc), 32'(DEPTH - n + 2));
        check("done_cpu_rst", 32'(cpu_rst), 32'd0);
        check("done_err", 32'(error), 32'd0);
        check("done_ready", 32'(in_ready), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_bad_len(input logic [7:0] l);
        int cyc;
        begin_frame();
        send(l);
        wait_flag(1'b0, cyc);
        check("len_err_latency", 32'(cyc), 32'd1);
        check("len_err_cpu_rst", 32'(cpu_rst), 32'd1);
        check("len_err_done", 32'(done), 32'd0);
        idle(5);
        check("len_err_sticky", 32'(error), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_adr", 32'(mem_adr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        rst = 1'b1;

`ifdef LOADER_CSUM_EN
        // Known frame 0x03,0x11,0x22,0x33 + checksum 0x66.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_good(3, 1'b0, 1'b0);
        // Same frame, bad checksum: error next cycle, no fill writes.
        begin
            int cyc;
            begin_frame();
            send(8'h03);
            for (int i = 0; i < 3; i++) begin
                sb.push_back({5'(i), pay[i]});
                send(pay[i]);
            end
            send(8'h65);
            wait_flag(1'b0, cyc);
            check("csum_err_latency", 32'(cyc), 32'd1);
            check("csum_err_cpu_rst", 32'(cpu_rst), 32'd1);
            idle(40);
            check("csum_err_sticky", 32'(error), 32'd1);
            check("csum_sb_empty", 32'(sb.size()), 32'd0);
        end
`else
        // Frame 0x02,0xAA,0xBB with no checksum byte.
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        run_good(2, 1'b0, 1'b0);
`endif
        run_bad_len(8'h00);
        run_bad_len(8'h21);

        // Full-depth image of 0xFF: no fill cycles.
        for (int i = 0; i < DEPTH; i++) pay[i] = 8'hFF;
        run_good(DEPTH, 1'b0, 1'b0);

        // Random payload with valid gaps and a stray start mid-load.
        for (int i = 0; i < DEPTH; i++) pay[i] = 8'($urandom);
        run_good(7, 1'b1, 1'b1);
        run_good(19, 1'b1, 1'b0);

        // Reset in the middle of a load: outputs fall back at once.
        begin_frame();
        send(8'd10);
        for (int i = 0; i < 3; i++) begin
            sb.push_back({5'(i), pay[i]});
            send(pay[i]);
        end
        #2 rst = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_adr", 32'(mem_adr), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(error), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check("post_rst_ready", 32'(in_ready), 32'd0);

        // Fresh loads after reset and again straight from DONE.
        run_good(5, 1'b0, 1'b0);
        run_good(12, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the multi-cycle stack processor.
- Sits upstream of the processor: accepts a length-framed byte stream over a valid/ready handshake and writes it into the 32×8 unified memory.
- Zero-fills the unused words and optionally verifies a checksum.
- Holds the processor in reset until the image is complete; only a good image releases it.

## Interface
Parameters:
- ADDR_W, default 5: memory address width.
- DATA_W, default 8: memory word / stream byte width.
- DEPTH, default 32: number of memory words (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load.
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  memory write strobe.
- mem_adr  output  ADDR_W  memory write address.
- mem_wdata  output  DATA_W  memory write data.
- cpu_rst  output  1  active-high reset to the processor.
- done  output  1  image loaded; processor released.
- error  output  1  frame rejected; processor held.

## Operation
- States: IDLE, LEN, LOAD, CSUM, FILL, DONE, ERROR.
- Handshake: a transfer occurs on an edge where in_valid && in_ready. in_ready is 1 only in LEN, LOAD and CSUM.
- IDLE, DONE, ERROR: start → LEN. Entry to LEN clears done, error, the byte counter and the checksum accumulator, and sets cpu_rst=1. start is ignored in every other state.
- LEN: the accepted byte is the length N.
  - N==0 or N>DEPTH → ERROR.
  - Otherwise store N and go to LOAD.
- LOAD: each accepted byte i (0..N-1) is written to address i. The checksum accumulator adds the byte modulo 2**DATA_W, with carry discarded. After byte N-1: → CSUM if LOADER_CSUM_EN, otherwise → FILL.
- CSUM: the accepted byte is compared with the accumulator.
  - Equal → FILL.
  - Mismatch → ERROR.
- FILL: writes 0 to addresses N..DEPTH-1, one per cycle, then → DONE.
  - If N==DEPTH, FILL lasts zero cycles and the block goes directly to DONE.
  - The address counter never wraps; the last address written is DEPTH-1.
- DONE: done=1, cpu_rst=0. Both hold until the next start.
- ERROR: error=1, cpu_rst=1. Both are sticky until the next start.
  - Payload words already written in ERROR are not cleared.
- in_valid with in_ready=0 is ignored. Gaps in in_valid stall the FSM indefinitely; there is no timeout.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_adr=0, mem_wdata=0, cpu_rst=1, done=0, error=0, state=IDLE.
- Reset asserted mid-load returns all outputs to the reset values immediately, without waiting for a clock edge.
- All outputs are registered.
- Payload write latency:
  - A byte accepted at edge k appears as mem_we=1 with address and data during the cycle after edge k.
  - mem_we is a single-cycle pulse per byte.
- FILL: mem_we is high for DEPTH-N consecutive cycles, with mem_adr incrementing by 1 each cycle.
- done and cpu_rst=0 become visible in the cycle after the last write cycle, whether that is the last fill or the last payload word.
- error becomes visible in the cycle after the rejecting byte is accepted.
- Throughput: 1 byte per cycle while in_valid is held high.

## Configuration
- LOADER_CSUM_EN defined:
  - A checksum byte follows the payload.
  - A mismatch leads to ERROR and no fill writes are issued.
- LOADER_CSUM_EN undefined:
  - CSUM state and accumulator are absent.
  - The payload goes straight to FILL and every well-formed length produces DONE.

## Test plan
1. LOADER_CSUM_EN defined, start, stream 0x03,0x11,0x22,0x33,0x66 → writes (0,0x11),(1,0x22),(2,0x33), then 29 zero writes at addresses 3..31. Then done=1 and cpu_rst=0; total frame-to-done is 5 transfers + 29 fill cycles + 1 cycle.
2. Same frame with checksum 0x65 → error=1 one cycle after the checksum is accepted, cpu_rst stays 1, no fill writes.
3. Length byte 0x00 → error=1. Length byte 0x21 (33) → error=1. No mem_we in either case.
4. Length 0x20 with 32 bytes of 0xFF and checksum 0xE0 → 32 payload writes, no fill cycles, done=1.
5. Toggle in_valid randomly during LOAD → identical memory contents. Pulse start mid-LOAD → ignored. Deassert rst mid-LOAD → all outputs at reset values at once. start from DONE → done=0, cpu_rst=1 and a new load begins.
6. LOADER_CSUM_EN undefined, stream 0x02,0xAA,0xBB → 2 writes, 30 fills, done=1, with no checksum byte consumed.
